// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O peripheral for the sc_computer data bus: switch/key inputs with
// synchronisers, key debounce and sticky press flags, plus LED and 7-segment outputs.
module mmio_io_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [2:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [6:0]  SEG0,
    output logic [6:0]  SEG1,
    output logic [6:0]  SEG2,
    output logic [6:0]  SEG3,
    output logic [6:0]  SEG4,
    output logic [6:0]  SEG5,
    output logic [9:0]  LED
);

    // Bus strobes, no handshake: we commits wdata to addr on the rising edge; re never
    // stalls and only qualifies the clear-on-read of KEYEVT; rdata is valid combinationally.
    localparam logic [2:0] A_SW       = 3'd0;
    localparam logic [2:0] A_KEYLVL   = 3'd1;
    localparam logic [2:0] A_KEYEVT   = 3'd2;
    localparam logic [2:0] A_LEDR     = 3'd3;
    localparam logic [2:0] A_HEXVAL   = 3'd4;
    localparam logic [2:0] A_HEXBLANK = 3'd5;
    localparam logic [7:0] DB_LIMIT   = 8'(DEBOUNCE_CYCLES);
    localparam logic [6:0] SEG_ZERO   = 7'b1000000;

    logic [SYNC_STAGES-1:0][3:0] key_sync;
    logic [SYNC_STAGES-1:0][9:0] sw_sync;
    logic [3:0]      key_s;
    logic [9:0]      sw_s;
    logic [3:0]      key_lvl;
    logic [3:0]      key_lvl_nxt;
    logic [3:0]      key_rise;
    logic [3:0][7:0] db_cnt;
    logic [3:0][7:0] db_cnt_nxt;
    logic [3:0]      key_evt;
    logic [3:0]      evt_clr;
    logic [9:0]      ledr;
    logic [23:0]     hexval;
    logic [5:0]      hexblank;
    logic [5:0][6:0] seg_q;
    logic            unused_wdata;

    assign unused_wdata = &{1'b0, wdata[31:24]};

    // KEY is inverted before synchronising so everything downstream treats pressed as 1.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_sync <= '0;
            sw_sync  <= '0;
        end else begin
            key_sync[0] <= ~KEY;
            sw_sync[0]  <= SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                key_sync[i] <= key_sync[i-1];
                sw_sync[i]  <= sw_sync[i-1];
            end
        end
    end

    assign key_s = key_sync[SYNC_STAGES-1];
    assign sw_s  = sw_sync[SYNC_STAGES-1];

    always_comb begin
        key_lvl_nxt = key_lvl;
        db_cnt_nxt  = db_cnt;
        key_rise    = '0;
        for (int k = 0; k < 4; k++) begin
            if (key_s[k] == key_lvl[k]) begin
                db_cnt_nxt[k] = '0;
            end else if (db_cnt[k] + 8'd1 == DB_LIMIT) begin
                key_lvl_nxt[k] = ~key_lvl[k];
                db_cnt_nxt[k]  = '0;
                key_rise[k]    = ~key_lvl[k];
            end else begin
                db_cnt_nxt[k] = db_cnt[k] + 8'd1;
            end
        end
    end

    // Read-clear wipes every flag, write-1-to-clear only the selected ones.
    always_comb begin
        evt_clr = '0;
        if (re && addr == A_KEYEVT) evt_clr = 4'hF;
        if (we && addr == A_KEYEVT) evt_clr = evt_clr | wdata[3:0];
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_lvl  <= '0;
            db_cnt   <= '0;
            key_evt  <= '0;
            ledr     <= '0;
            hexval   <= '0;
            hexblank <= '0;
        end else begin
            key_lvl <= key_lvl_nxt;
            db_cnt  <= db_cnt_nxt;
            key_evt <= (key_evt & ~evt_clr) | key_rise;
            if (we) begin
                case (addr)
                    A_LEDR:     ledr     <= wdata[9:0];
                    A_HEXVAL:   hexval   <= wdata[23:0];
                    A_HEXBLANK: hexblank <= wdata[5:0];
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seg_q <= {6{SEG_ZERO}};
        end else begin
            for (int n = 0; n < 6; n++) begin
                seg_q[n] <= hexblank[n] ? 7'b1111111 : hex7(hexval[4*n +: 4]);
            end
        end
    end

    assign SEG0 = seg_q[0];
    assign SEG1 = seg_q[1];
    assign SEG2 = seg_q[2];
    assign SEG3 = seg_q[3];
    assign SEG4 = seg_q[4];
    assign SEG5 = seg_q[5];
    assign LED  = ledr;

    always_comb begin
        rdata = '0;
        case (addr)
            A_SW:       rdata[9:0]  = sw_s;
            A_KEYLVL:   rdata[3:0]  = key_lvl;
            A_KEYEVT:   rdata[3:0]  = key_evt;
            A_LEDR:     rdata[9:0]  = ledr;
            A_HEXVAL:   rdata[23:0] = hexval;
            A_HEXBLANK: rdata[5:0]  = hexblank;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed bench for mmio_io_ctrl: register/segment vector table plus hand-written
// key debounce, event flag, sync latency and reset sequences.
module tb_mmio_io_ctrl;

    localparam logic [6:0] S_0  = 7'b1000000;
    localparam logic [6:0] S_1  = 7'b1111001;
    localparam logic [6:0] S_2  = 7'b0100100;
    localparam logic [6:0] S_3  = 7'b0110000;
    localparam logic [6:0] S_4  = 7'b0011001;
    localparam logic [6:0] S_5  = 7'b0010010;
    localparam logic [6:0] S_6  = 7'b0000010;
    localparam logic [6:0] S_7  = 7'b1111000;
    localparam logic [6:0] S_8  = 7'b0000000;
    localparam logic [6:0] S_9  = 7'b0010000;
    localparam logic [6:0] S_A  = 7'b0001000;
    localparam logic [6:0] S_B  = 7'b0000011;
    localparam logic [6:0] S_C  = 7'b1000110;
    localparam logic [6:0] S_D  = 7'b0100001;
    localparam logic [6:0] S_E  = 7'b0000110;
    localparam logic [6:0] S_F  = 7'b0001110;
    localparam logic [6:0] S_BL = 7'b1111111;

    typedef struct packed {
        logic [2:0]  waddr;
        logic [31:0] wdata;
        logic [2:0]  raddr;
        logic [31:0] exp_rdata;
        logic [9:0]  exp_led;
        logic [41:0] exp_seg;
    } vec_t;

    logic        clock;
    logic        resetn;
    logic [2:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [6:0]  SEG0, SEG1, SEG2, SEG3, SEG4, SEG5;
    logic [9:0]  LED;

    int   errors = 0;
    int   checks = 0;
    vec_t vec [14];

    mmio_io_ctrl #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clock (clock),
        .resetn(resetn),
        .addr  (addr),
        .we    (we),
        .re    (re),
        .wdata (wdata),
        .rdata (rdata),
        .KEY   (KEY),
        .SW    (SW),
        .SEG0  (SEG0),
        .SEG1  (SEG1),
        .SEG2  (SEG2),
        .SEG3  (SEG3),
        .SEG4  (SEG4),
        .SEG5  (SEG5),
        .LED   (LED)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    function automatic logic [41:0] segs();
        return {SEG5, SEG4, SEG3, SEG2, SEG1, SEG0};
    endfunction

    initial begin
        logic [31:0] d;

        vec[0]  = '{3'd3, 32'h0000_03FF, 3'd3, 32'h3FF, 10'h3FF, {S_0, S_0, S_0, S_0, S_0, S_0}};
        vec[1]  = '{3'd4, 32'h0000_A5F3, 3'd4, 32'h00A5F3, 10'h3FF, {S_0, S_0, S_A, S_5, S_F, S_3}};
        vec[2]  = '{3'd5, 32'h0000_0020, 3'd5, 32'h20, 10'h3FF, {S_BL, S_0, S_A, S_5, S_F, S_3}};
        vec[3]  = '{3'd0, 32'h0000_FFFF, 3'd3, 32'h3FF, 10'h3FF, {S_BL, S_0, S_A, S_5, S_F, S_3}};
        vec[4]  = '{3'd1, 32'h0000_FFFF, 3'd4, 32'h00A5F3, 10'h3FF, {S_BL, S_0, S_A, S_5, S_F, S_3}};
        vec[5]  = '{3'd6, 32'hFFFF_FFFF, 3'd6, 32'h0, 10'h3FF, {S_BL, S_0, S_A, S_5, S_F, S_3}};
        vec[6]  = '{3'd3, 32'hFFFF_F155, 3'd3, 32'h155, 10'h155, {S_BL, S_0, S_A, S_5, S_F, S_3}};
        vec[7]  = '{3'd4, 32'h1234_5678, 3'd4, 32'h345678, 10'h155, {S_BL, S_4, S_5, S_6, S_7, S_8}};
        vec[8]  = '{3'd5, 32'hFFFF_FFC0, 3'd5, 32'h0, 10'h155, {S_3, S_4, S_5, S_6, S_7, S_8}};
        vec[9]  = '{3'd4, 32'h000B_CDE9, 3'd4, 32'h0BCDE9, 10'h155, {S_0, S_B, S_C, S_D, S_E, S_9}};
        vec[10] = '{3'd5, 32'h0000_0015, 3'd5, 32'h15, 10'h155, {S_0, S_BL, S_C, S_BL, S_E, S_BL}};
        vec[11] = '{3'd4, 32'h0000_0021, 3'd4, 32'h21, 10'h155, {S_0, S_BL, S_0, S_BL, S_2, S_BL}};
        vec[12] = '{3'd5, 32'h0000_0000, 3'd0, 32'h005, 10'h155, {S_0, S_0, S_0, S_0, S_2, S_1}};
        vec[13] = '{3'd7, 32'hFFFF_FFFF, 3'd7, 32'h0, 10'h155, {S_0, S_0, S_0, S_0, S_2, S_1}};

        // Reset held with keys released and SW = 3
        resetn = 1'b0; addr = '0; we = 1'b0; re = 1'b0; wdata = '0;
        KEY = 4'hF; SW = 10'd3;
        repeat (12) tick();
        check("reset_led", 64'(LED), 64'h0);
        check("reset_seg", 64'(segs()), 64'({6{S_0}}));
        rd(3'd1, d); check("reset_keylvl", 64'(d), 64'h0);
        rd(3'd2, d); check("reset_keyevt", 64'(d), 64'h0);
        rd(3'd0, d); check("reset_sw", 64'(d), 64'h0);
        resetn = 1'b1;
        tick(); rd(3'd0, d); check("sw_lat_1", 64'(d), 64'h0);
        tick(); rd(3'd0, d); check("sw_lat_2", 64'(d), 64'h3);

        // KEY[1] press: level appears exactly 6 edges after the pin change
        KEY = 4'b1101;
        for (int i = 1; i <= 20; i++) begin
            tick();
            rd(3'd1, d);
            if (i == 5)  check("press_lvl_5", 64'(d), 64'h0);
            if (i == 6)  check("press_lvl_6", 64'(d), 64'h2);
            if (i == 20) check("press_lvl_20", 64'(d), 64'h2);
        end
        re = 1'b1;
        rd(3'd2, d); check("evt_read", 64'(d), 64'h2);
        tick(); re = 1'b0;
        rd(3'd2, d); check("evt_after_read", 64'(d), 64'h0);
        KEY = 4'hF;
        repeat (10) tick();
        rd(3'd1, d); check("release_lvl", 64'(d), 64'h0);
        rd(3'd2, d); check("release_evt", 64'(d), 64'h0);

        // Glitch of 3 cycles on KEY[0]
        KEY = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            tick(); rd(3'd1, d); check("glitch_lvl", 64'(d), 64'h0);
        end
        KEY = 4'hF;
        for (int i = 0; i < 7; i++) begin
            tick(); rd(3'd1, d); check("glitch_lvl_after", 64'(d), 64'h0);
        end
        rd(3'd2, d); check("glitch_evt", 64'(d), 64'h0);

        // Press edge coinciding with a clearing read: event wins
        KEY = 4'b1101;
        repeat (5) tick();
        rd(3'd1, d); check("coinc_lvl_pre", 64'(d), 64'h0);
        re = 1'b1;
        rd(3'd2, d); check("coinc_rdata", 64'(d), 64'h0);
        tick(); re = 1'b0;
        rd(3'd2, d); check("coinc_evt", 64'(d), 64'h2);
        rd(3'd1, d); check("coinc_lvl", 64'(d), 64'h2);

        // Write-1-to-clear of bit 0 with both flags set
        KEY = 4'b1100;
        repeat (6) tick();
        rd(3'd2, d); check("w1c_pre", 64'(d), 64'h3);
        we = 1'b1; wdata = 32'h1;
        tick(); we = 1'b0; wdata = '0;
        rd(3'd2, d); check("w1c_post", 64'(d), 64'h2);
        KEY = 4'hF;
        repeat (8) tick();
        rd(3'd1, d); check("w1c_release_lvl", 64'(d), 64'h0);
        rd(3'd2, d); check("w1c_release_evt", 64'(d), 64'h2);
        re = 1'b1; addr = 3'd2;
        tick(); re = 1'b0;
        rd(3'd2, d); check("evt_cleared", 64'(d), 64'h0);

        // SW change 3 -> 5
        SW = 10'd5;
        tick(); rd(3'd0, d); check("sw_change_1", 64'(d), 64'h3);
        tick(); rd(3'd0, d); check("sw_change_2", 64'(d), 64'h5);

        // Register / segment vectors
        for (int v = 0; v < 14; v++) begin
            addr = vec[v].waddr; wdata = vec[v].wdata; we = 1'b1;
            tick();
            we = 1'b0; wdata = '0;
            tick();
            rd(vec[v].raddr, d);
            check($sformatf("vec%0d_rdata", v), 64'(d), 64'(vec[v].exp_rdata));
            check($sformatf("vec%0d_led", v), 64'(LED), 64'(vec[v].exp_led));
            check($sformatf("vec%0d_seg", v), 64'(segs()), 64'(vec[v].exp_seg));
        end

        // Reset asserted mid-debounce discards partial counts
        KEY = 4'b1011;
        repeat (6) tick();
        rd(3'd2, d); check("mid_evt_pre", 64'(d), 64'h4);
        KEY = 4'b0011;
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        check("mid_rst_led", 64'(LED), 64'h0);
        check("mid_rst_seg", 64'(segs()), 64'({6{S_0}}));
        rd(3'd1, d); check("mid_rst_keylvl", 64'(d), 64'h0);
        rd(3'd2, d); check("mid_rst_keyevt", 64'(d), 64'h0);
        rd(3'd3, d); check("mid_rst_ledr", 64'(d), 64'h0);
        rd(3'd4, d); check("mid_rst_hexval", 64'(d), 64'h0);
        rd(3'd0, d); check("mid_rst_sw", 64'(d), 64'h0);
        repeat (2) tick();
        resetn = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            rd(3'd1, d);
            if (i == 5) check("post_rst_lvl_5", 64'(d), 64'h0);
            if (i == 6) check("post_rst_lvl_6", 64'(d), 64'hC);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
